// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the sequence generator and the receive-side checker.
package lfsr_pkg;

    localparam int LFSR_N = 14;
    localparam logic [LFSR_N-1:0] LFSR_TAP_MASK = 14'h2015;

    typedef enum logic {
        SEED   = 1'b0,
        LOCKED = 1'b1
    } checker_state_t;

endpackage

// File: rtl/lfsr_step.sv
// One Fibonacci LFSR step: the feedback bit and the shifted state that follows it.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int N = LFSR_N
) (
    input  logic [N-1:0] s,
    input  logic [N-1:0] mask,
    output logic         pred,
    output logic [N-1:0] next_s
);

    assign pred   = ^(s & mask);
    assign next_s = {s[N-2:0], pred};

endmodule

// File: rtl/lfsr_sequence_checker.sv
// Self-seeding LFSR stream checker: locks onto the received sequence, then predicts
// each bit and reports mismatches, loss of lock and period completion.
module lfsr_sequence_checker
    import lfsr_pkg::*;
#(
    parameter int             N         = LFSR_N,
    parameter logic [N-1:0]   TAP_MASK  = LFSR_TAP_MASK,
    parameter int             ERR_LIMIT = 8,
    parameter int             ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 lost_pulse,
    output logic                 period_tick,
    output logic [ERR_CNT_W-1:0] error_count
);

    localparam int SEED_CNT_W = $clog2(N + 1);
    localparam logic [SEED_CNT_W-1:0] SEED_LAST = SEED_CNT_W'(N - 1);
    localparam logic [7:0] LIMIT = 8'(ERR_LIMIT);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    checker_state_t        state;
    logic [N-1:0]          s;
    logic [N-1:0]          seed_state;
    logic [SEED_CNT_W-1:0] seed_cnt;
    logic [7:0]            consec;

    logic                  pred;
    logic [N-1:0]          next_s;
    logic [N-1:0]          seed_s;
    logic                  mismatch;
    logic [7:0]            consec_next;
    logic                  lost_now;

    lfsr_step #(.N(N)) u_step (
        .s      (s),
        .mask   (TAP_MASK),
        .pred   (pred),
        .next_s (next_s)
    );

    assign seed_s      = {s[N-2:0], bit_in};
    assign mismatch    = bit_in ^ pred;
    assign consec_next = mismatch ? consec + 8'd1 : 8'd0;
    assign lost_now    = mismatch && (consec_next == LIMIT);

    // While locked, s follows the prediction only, so received errors never corrupt it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SEED;
            s           <= '0;
            seed_state  <= '0;
            seed_cnt    <= '0;
            consec      <= '0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            lost_pulse  <= 1'b0;
            period_tick <= 1'b0;
            error_count <= '0;
        end else begin
            err_pulse   <= 1'b0;
            lost_pulse  <= 1'b0;
            period_tick <= 1'b0;
            if (bit_valid) begin
                case (state)
                    SEED: begin
                        s <= seed_s;
                        if (seed_cnt == SEED_LAST) begin
                            seed_cnt <= '0;
                            if (seed_s != '0) begin
                                seed_state <= seed_s;
                                state      <= LOCKED;
                                locked     <= 1'b1;
                                consec     <= '0;
                            end
                        end else begin
                            seed_cnt <= seed_cnt + 1'b1;
                        end
                    end
                    LOCKED: begin
                        err_pulse <= mismatch;
                        if (mismatch && (error_count != CNT_MAX)) begin
                            error_count <= error_count + 1'b1;
                        end
                        if (lost_now) begin
                            lost_pulse <= 1'b1;
                            locked     <= 1'b0;
                            state      <= SEED;
                            s          <= '0;
                            seed_cnt   <= '0;
                            consec     <= '0;
                        end else begin
                            s           <= next_s;
                            consec      <= consec_next;
                            period_tick <= (next_s == seed_state);
                        end
                    end
                    default: state <= SEED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// Bench for lfsr_sequence_checker: a recurrence-based stream source and a bit-queue
// model of lock/predict behaviour, compared against two DUT builds every cycle.
module tb_lfsr_sequence_checker;

    localparam int PERIOD = 16383;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;

    logic        locked_a, err_a, lost_a, tick_a;
    logic [15:0] count_a;
    logic        locked_b, err_b, lost_b, tick_b;
    logic [3:0]  count_b;

    int n_assert = 0;
    int n_fail = 0;

    bit m_locked, m_err, m_lost, m_tick;
    int m_count16, m_count4, consec;
    bit seed_q[$];
    bit win_q[$];
    bit seed_win[$];
    bit gen_q[$];
    int vb = 0;
    int last_tick = 0;
    bit tick_armed = 0;
    int ticks_seen = 0;

    always #5 clk = ~clk;

    lfsr_sequence_checker dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .locked      (locked_a),
        .err_pulse   (err_a),
        .lost_pulse  (lost_a),
        .period_tick (tick_a),
        .error_count (count_a)
    );

    lfsr_sequence_checker #(.ERR_CNT_W(4)) dut_small (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .locked      (locked_b),
        .err_pulse   (err_b),
        .lost_pulse  (lost_b),
        .period_tick (tick_b),
        .error_count (count_b)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Source stream obeys b[t] = b[t-1]^b[t-3]^b[t-5]^b[t-14]; gen_q[13] is the newest bit.
    task automatic genSeed();
        logic [13:0] rv;
        rv = 14'($urandom_range(1, PERIOD));
        gen_q.delete();
        for (int k = 0; k < 14; k++) gen_q.push_back(rv[k]);
    endtask

    task automatic genNext(output bit b);
        b = gen_q[13] ^ gen_q[11] ^ gen_q[9] ^ gen_q[0];
        gen_q.push_back(b);
        void'(gen_q.pop_front());
    endtask

    task automatic modelReset();
        m_locked = 0; m_err = 0; m_lost = 0; m_tick = 0;
        m_count16 = 0; m_count4 = 0; consec = 0;
        seed_q.delete();
        tick_armed = 0;
    endtask

    task automatic modelStep(input bit b, input bit v);
        bit nz;
        bit p;
        bit same;
        m_err = 0; m_lost = 0; m_tick = 0;
        if (v) begin
            if (!m_locked) begin
                seed_q.push_back(b);
                if (seed_q.size() == 14) begin
                    nz = 0;
                    foreach (seed_q[k]) nz |= seed_q[k];
                    if (nz) begin
                        m_locked = 1;
                        win_q = seed_q;
                        seed_win = seed_q;
                        consec = 0;
                        tick_armed = 1;
                        last_tick = vb;
                    end
                    seed_q.delete();
                end
            end else begin
                p = win_q[13] ^ win_q[11] ^ win_q[9] ^ win_q[0];
                if (b != p) begin
                    m_err = 1;
                    if (m_count16 < 65535) m_count16++;
                    if (m_count4 < 15) m_count4++;
                    consec++;
                end else begin
                    consec = 0;
                end
                if (consec == 8) begin
                    m_lost = 1;
                    m_locked = 0;
                    consec = 0;
                    seed_q.delete();
                    tick_armed = 0;
                end else begin
                    win_q.push_back(p);
                    void'(win_q.pop_front());
                    same = 1;
                    for (int k = 0; k < 14; k++) if (win_q[k] != seed_win[k]) same = 0;
                    m_tick = same;
                end
            end
        end
    endtask

    task automatic checkOutput(input string ph);
        check({ph, ".locked"},       32'(locked_a), 32'(m_locked));
        check({ph, ".err_pulse"},    32'(err_a),    32'(m_err));
        check({ph, ".lost_pulse"},   32'(lost_a),   32'(m_lost));
        check({ph, ".period_tick"},  32'(tick_a),   32'(m_tick));
        check({ph, ".error_count"},  32'(count_a),  32'(m_count16));
        check({ph, ".locked_w4"},    32'(locked_b), 32'(m_locked));
        check({ph, ".err_pulse_w4"}, 32'(err_b),    32'(m_err));
        check({ph, ".lost_w4"},      32'(lost_b),   32'(m_lost));
        check({ph, ".tick_w4"},      32'(tick_b),   32'(m_tick));
        check({ph, ".count_w4"},     32'(count_b),  32'(m_count4));
    endtask

    task automatic applyStimulus(input string ph, input bit b, input bit v);
        bit armed;
        bit_in = b;
        bit_valid = v;
        if (v) vb++;
        modelStep(b, v);
        armed = tick_armed;
        @(posedge clk);
        #1;
        checkOutput(ph);
        if (tick_a === 1'b1) begin
            ticks_seen++;
            if (armed) check({ph, ".tick_spacing"}, 32'(vb - last_tick), 32'(PERIOD));
            last_tick = vb;
        end
    endtask

    // Called just after an active edge; drops reset mid-cycle and checks outputs at once.
    task automatic applyReset(input string ph);
        #2;
        rst = 1'b0;
        bit_valid = 1'b0;
        #1;
        modelReset();
        checkOutput(ph);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        bit g;
        int single_pos;
        int iso_start;
        int n_bits;

        modelReset();
        #2 rst = 1'b0;
        #1 checkOutput("power_on_reset");
        @(posedge clk);
        #1 rst = 1'b1;

        $display("[TB] constant zero stream");
        for (int i = 0; i < 100; i++) applyStimulus("zeros", 1'b0, 1'b1);
        check("zeros.never_locked", 32'(locked_a), 32'd0);
        applyReset("reset_after_zeros");

        $display("[TB] clean stream with single and isolated errors, three periods");
        genSeed();
        ticks_seen = 0;
        single_pos = 14 + int'($urandom_range(50, 16000));
        iso_start  = 14 + 2 * PERIOD + int'($urandom_range(50, 16000 - 60));
        n_bits     = 14 + 3 * PERIOD + 2;
        for (int i = 0; i < n_bits; i++) begin
            genNext(g);
            if (i == single_pos) g = ~g;
            if (i >= iso_start && i < iso_start + 60 && ((i - iso_start) % 3) == 0) g = ~g;
            applyStimulus("clean", g, 1'b1);
            if (i == 13) check("clean.lock_after_14", 32'(locked_a), 32'd1);
            if (i == single_pos) check("single.count_is_1", 32'(count_a), 32'd1);
        end
        check("clean.ticks_3", 32'(ticks_seen), 32'd3);
        check("isolated.count_w16", 32'(count_a), 32'd21);
        check("isolated.count_w4_saturated", 32'(count_b), 32'd15);

        $display("[TB] burst errors");
        for (int i = 0; i < 20; i++) begin genNext(g); applyStimulus("burst_pre", g, 1'b1); end
        for (int i = 0; i < 7; i++) begin genNext(g); applyStimulus("burst7", ~g, 1'b1); end
        check("burst7.still_locked", 32'(locked_a), 32'd1);
        for (int i = 0; i < 20; i++) begin genNext(g); applyStimulus("burst_mid", g, 1'b1); end
        for (int i = 0; i < 8; i++) begin genNext(g); applyStimulus("burst8", ~g, 1'b1); end
        check("burst8.lost_pulse", 32'(lost_a), 32'd1);
        check("burst8.unlocked", 32'(locked_a), 32'd0);
        check("burst8.count", 32'(count_a), 32'd36);
        for (int i = 0; i < 14; i++) begin genNext(g); applyStimulus("relock", g, 1'b1); end
        check("relock.locked", 32'(locked_a), 32'd1);
        for (int i = 0; i < 16; i++) begin genNext(g); applyStimulus("post_relock", g, 1'b1); end

        $display("[TB] alternating bit_valid");
        applyReset("reset_before_toggle");
        genSeed();
        ticks_seen = 0;
        for (int i = 0; i < 2 * (14 + PERIOD + 2); i++) begin
            if ((i % 2) == 0) begin
                genNext(g);
                applyStimulus("toggle", g, 1'b1);
            end else begin
                applyStimulus("toggle_idle", 1'($urandom), 1'b0);
            end
            if (i == 26) check("toggle.lock_after_14_valid", 32'(locked_a), 32'd1);
        end
        check("toggle.ticks_1", 32'(ticks_seen), 32'd1);

        $display("[TB] reset while locked");
        applyReset("reset_mid_lock");
        check("reset_mid_lock.locked_zero", 32'(locked_a), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
